text_buffer: RTL

Character-cell text memory for the 16×16-cell text overlay. It accepts a byte stream (ASCII plus a few control codes) over a valid/ready handshake and maintains a write cursor. It answers the overlay drawer's per-pixel `char_xy` lookups with a registered 7-bit character code, which feeds the font ROM address together with `char_line`.

---
 rtl/text_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : text_buffer
// Brief    : 16x16-cell text memory for the overlay. Accepts a byte stream
//            over valid/ready, keeps a write cursor, handles newline,
//            backspace and clear codes, and serves registered per-pixel
//            character lookups for the font ROM.
// Options  : TEXT_BUF_CURSOR_EN - blinking cursor glyph at the write cursor.
// Revision : 1.0 - initial release
// ============================================================================
module text_buffer #(
  parameter logic [6:0] CLEAR_CHAR  = 7'h20,
  parameter logic [6:0] CURSOR_CHAR = 7'h5F
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear_req,
  input  logic       frame_tick,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [3:0] w_cx_nxt;
  logic [3:0] w_cy_nxt;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [6:0] w_wdata;
  logic       w_accept;
  logic [6:0] w_code;
  logic [3:0] w_cx_dec;
  logic [3:0] w_cy_dec;
  logic       w_cursor_hit;
  logic [6:0] r_mem [256];

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state == ST_CLEAR);
  assign w_accept = in_valid && in_ready;
  assign w_code   = in_data[6:0];
  assign w_cx_dec = cursor_x - 4'd1;
  assign w_cy_dec = cursor_y - 4'd1;

  // State, sweep counter and cursor registers; reset always restarts the sweep
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_cnt    <= 8'd0;
      cursor_x <= 4'd0;
      cursor_y <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      cursor_x <= w_cx_nxt;
      cursor_y <= w_cy_nxt;
    end
  end

  // Next-state, cursor update and the single memory write port
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cx_nxt    = cursor_x;
    w_cy_nxt    = cursor_y;
    w_we        = 1'b0;
    w_waddr     = {cursor_y, cursor_x};
    w_wdata     = CLEAR_CHAR;
    case (r_state)
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'hFF) begin
          w_state_nxt = ST_IDLE;
          w_cx_nxt    = 4'd0;
          w_cy_nxt    = 4'd0;
        end
      end
      default: begin
        // A clear request beats any byte transferred in the same cycle
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = 8'd0;
        end else if (w_accept && !in_data[7]) begin
          if (w_code >= 7'h20 && w_code <= 7'h7E) begin
            w_we     = 1'b1;
            w_wdata  = w_code;
            w_cx_nxt = cursor_x + 4'd1;
            if (cursor_x == 4'hF) begin
              w_cy_nxt = cursor_y + 4'd1;
            end
          end else if (w_code == 7'h0A || w_code == 7'h0D) begin
            w_cx_nxt = 4'd0;
            w_cy_nxt = cursor_y + 4'd1;
          end else if (w_code == 7'h08) begin
            if (cursor_x != 4'd0) begin
              w_cx_nxt = w_cx_dec;
              w_we     = 1'b1;
              w_waddr  = {cursor_y, w_cx_dec};
            end else if (cursor_y != 4'd0) begin
              w_cx_nxt = 4'hF;
              w_cy_nxt = w_cy_dec;
              w_we     = 1'b1;
              w_waddr  = {w_cy_dec, 4'hF};
            end
          end else if (w_code == 7'h0C) begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
    endcase
  end

`ifdef TEXT_BUF_CURSOR_EN
  logic [4:0] r_blink;

  // Frame counter; its MSB gives a 32-frame blink period
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_blink <= 5'd0;
    end else if (frame_tick) begin
      r_blink <= r_blink + 5'd1;
    end
  end

  assign w_cursor_hit = r_blink[4] && (r_state == ST_IDLE) &&
                        (char_xy == {cursor_y, cursor_x});
`else
  logic w_unused_cursor;
  assign w_unused_cursor = frame_tick ^ (|CURSOR_CHAR);
  assign w_cursor_hit    = 1'b0;
`endif

  // Cell storage; no reset, contents become defined by the clear sweep
  always_ff @(posedge pclk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read port, read-first against a same-cycle write
  always_ff @(posedge pclk) begin
    if (rst) begin
      char_code <= CLEAR_CHAR;
    end else if (w_cursor_hit) begin
      char_code <= CURSOR_CHAR;
    end else begin
      char_code <= r_mem[char_xy];
    end
  end

endmodule
`default_nettype wire
